// File: rtl/intersection_pkg.sv
// Shared types and elaboration-time checks for the two-way intersection controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5
  } state_t;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } light_t;

  // Every duration must be at least one cycle and its load value (duration-1) must fit the timer.
  function automatic bit durations_ok(input int nbits, input int t_main, input int t_side,
                                      input int t_yel, input int t_ar);
    int mx;
    mx = t_main;
    if (t_side > mx) mx = t_side;
    if (t_yel > mx) mx = t_yel;
    if (t_ar > mx) mx = t_ar;
    return (t_main >= 1) && (t_side >= 1) && (t_yel >= 1) && (t_ar >= 1) &&
           (nbits >= 1) && (nbits <= 30) && ((mx - 1) < (1 << nbits));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; flags zero for the phase FSM.
module phase_timer #(
  parameter int NBITS_TIMER = 4,
  parameter int RESET_VAL   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBITS_TIMER-1:0] load_val,
  output logic                   zero
);

  logic [NBITS_TIMER-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= NBITS_TIMER'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Main/side intersection sequencer with pedestrian walk on the side phase.
// Main street rests on green and yields only after its minimum time when a request is pending.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int T_MAIN_MIN  = 8,
  parameter int T_SIDE      = 6,
  parameter int T_YEL       = 3,
  parameter int T_AR        = 2,
  parameter int NBITS_TIMER = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_side,
  input  logic       ped_req,
  output logic       main_g,
  output logic       main_y,
  output logic       main_r,
  output logic       side_g,
  output logic       side_y,
  output logic       side_r,
  output logic       ped_walk,
  output logic [2:0] phase
);

  if (!durations_ok(NBITS_TIMER, T_MAIN_MIN, T_SIDE, T_YEL, T_AR)) begin : g_bad_durations
    $error("intersection_ctrl: phase durations must be >=1 and fit NBITS_TIMER");
  end

  localparam logic [NBITS_TIMER-1:0] LD_MAIN = NBITS_TIMER'(T_MAIN_MIN - 1);
  localparam logic [NBITS_TIMER-1:0] LD_SIDE = NBITS_TIMER'(T_SIDE - 1);
  localparam logic [NBITS_TIMER-1:0] LD_YEL  = NBITS_TIMER'(T_YEL - 1);
  localparam logic [NBITS_TIMER-1:0] LD_AR   = NBITS_TIMER'(T_AR - 1);

  state_t                 state_q, state_d;
  logic                   ped_pending_q, ped_pending_d;
  logic                   walk_grant_q, walk_grant_d;
  logic                   tmr_load, tmr_zero;
  logic [NBITS_TIMER-1:0] tmr_val;
  logic                   grant_evt, leave_side;
  light_t                 main_l, side_l;

  phase_timer #(
    .NBITS_TIMER(NBITS_TIMER),
    .RESET_VAL  (T_MAIN_MIN - 1)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_val    = LD_MAIN;
    grant_evt  = 1'b0;
    leave_side = 1'b0;
    case (state_q)
      // Main green holds with the timer parked at zero until someone asks to cross.
      MAIN_GREEN: if (tmr_zero && (sensor_side || ped_pending_q || ped_req)) begin
        state_d   = MAIN_YELLOW;
        tmr_load  = 1'b1;
        tmr_val   = LD_YEL;
        grant_evt = 1'b1;
      end
      MAIN_YELLOW: if (tmr_zero) begin
        state_d  = ALL_RED_1;
        tmr_load = 1'b1;
        tmr_val  = LD_AR;
      end
      ALL_RED_1: if (tmr_zero) begin
        state_d  = SIDE_GREEN;
        tmr_load = 1'b1;
        tmr_val  = LD_SIDE;
      end
      SIDE_GREEN: if (tmr_zero) begin
        state_d    = SIDE_YELLOW;
        tmr_load   = 1'b1;
        tmr_val    = LD_YEL;
        leave_side = 1'b1;
      end
      SIDE_YELLOW: if (tmr_zero) begin
        state_d  = ALL_RED_2;
        tmr_load = 1'b1;
        tmr_val  = LD_AR;
      end
      ALL_RED_2: if (tmr_zero) begin
        state_d  = MAIN_GREEN;
        tmr_load = 1'b1;
        tmr_val  = LD_MAIN;
      end
      default: begin
        state_d  = MAIN_GREEN;
        tmr_load = 1'b1;
        tmr_val  = LD_MAIN;
      end
    endcase
  end

  // A request on the grant cycle is folded into this walk; any later one waits for the next cycle.
  always_comb begin
    ped_pending_d = grant_evt ? 1'b0 : (ped_pending_q | ped_req);
    walk_grant_d  = walk_grant_q;
    if (grant_evt) begin
      walk_grant_d = ped_pending_q | ped_req;
    end else if (leave_side) begin
      walk_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MAIN_GREEN;
      ped_pending_q <= 1'b0;
      walk_grant_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      walk_grant_q  <= walk_grant_d;
    end
  end

  always_comb begin
    main_l = '{g: 1'b0, y: 1'b0, r: 1'b1};
    side_l = '{g: 1'b0, y: 1'b0, r: 1'b1};
    case (state_q)
      MAIN_GREEN:  main_l = '{g: 1'b1, y: 1'b0, r: 1'b0};
      MAIN_YELLOW: main_l = '{g: 1'b0, y: 1'b1, r: 1'b0};
      SIDE_GREEN:  side_l = '{g: 1'b1, y: 1'b0, r: 1'b0};
      SIDE_YELLOW: side_l = '{g: 1'b0, y: 1'b1, r: 1'b0};
      default: ;
    endcase
  end

  assign main_g   = main_l.g;
  assign main_y   = main_l.y;
  assign main_r   = main_l.r;
  assign side_g   = side_l.g;
  assign side_y   = side_l.y;
  assign side_r   = side_l.r;
  assign ped_walk = walk_grant_q && (state_q == SIDE_GREEN);
  assign phase    = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed schedules from the test plan plus random traffic
// compared against a phase/elapsed-time reference model.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_side = 1'b0;
  logic       ped_req = 1'b0;
  logic       main_g, main_y, main_r, side_g, side_y, side_r, ped_walk;
  logic [2:0] phase;
  logic [9:0] dut_vec;

  int total = 0;
  int bad = 0;

  // Reference model: phase index, cycles spent in it, and request bookkeeping.
  int m_p = 0;
  int m_e = 0;
  bit m_pend = 0;
  bit m_grant = 0;
  int dur[6] = '{4, 2, 1, 3, 2, 1};

  localparam logic [9:0] RESET_VEC = 10'b100001_0_000;

  intersection_ctrl #(
    .T_MAIN_MIN (4),
    .T_SIDE     (3),
    .T_YEL      (2),
    .T_AR       (1),
    .NBITS_TIMER(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_side(sensor_side),
    .ped_req    (ped_req),
    .main_g     (main_g),
    .main_y     (main_y),
    .main_r     (main_r),
    .side_g     (side_g),
    .side_y     (side_y),
    .side_r     (side_r),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  assign dut_vec = {main_g, main_y, main_r, side_g, side_y, side_r, ped_walk, phase};

  function automatic logic [9:0] exp_vec();
    logic mg, my, mr, sg, sy, sr, w;
    mg = (m_p == 0);
    my = (m_p == 1);
    mr = (m_p >= 2);
    sg = (m_p == 3);
    sy = (m_p == 4);
    sr = (m_p <= 2) || (m_p == 5);
    w  = (m_p == 3) && m_grant;
    return {mg, my, mr, sg, sy, sr, w, 3'(m_p)};
  endfunction

  // Phase expected c cycles into a schedule whose main yellow begins at cycle y (single side service).
  function automatic int dir_phase(input int c, input int y);
    int o;
    if (c < y) return 0;
    o = c - y;
    if (o < 2) return 1;
    if (o < 3) return 2;
    if (o < 6) return 3;
    if (o < 8) return 4;
    if (o < 9) return 5;
    return 0;
  endfunction

  task automatic tick(input bit s, input bit p, input bit r);
    sensor_side = s;
    ped_req     = p;
    reset       = r;
    @(posedge clk);
    if (r) begin
      m_p = 0; m_e = 0; m_pend = 0; m_grant = 0;
    end else if (m_e + 1 < dur[m_p]) begin
      m_e++;
      m_pend = m_pend | p;
    end else if (m_p == 0 && !(s || m_pend || p)) begin
      m_pend = m_pend | p;
    end else begin
      if (m_p == 0) begin
        m_grant = m_pend | p;
        m_pend  = 0;
      end else begin
        m_pend = m_pend | p;
        if (m_p == 3) m_grant = 0;
      end
      m_p = (m_p + 1) % 6;
      m_e = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    tick(0, 0, 1);
  endtask

  task automatic test_reset();
    tick(0, 0, 1);
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++; $display("FAIL reset_idle got=%b want=%b", dut_vec, RESET_VEC);
    end
    tick(1, 1, 1);
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++; $display("FAIL reset_with_inputs got=%b want=%b", dut_vec, RESET_VEC);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      total++;
      if (dut_vec !== RESET_VEC) begin
        bad++; $display("FAIL idle c=%0d got=%b want=%b", c, dut_vec, RESET_VEC);
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_sensor();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      total++;
      if (phase !== 3'(dir_phase(c % 13, 4)) || ped_walk !== 1'b0) begin
        bad++; $display("FAIL sensor_phase c=%0d got=%0d/%b want=%0d/0", c, phase, ped_walk,
                        dir_phase(c % 13, 4));
      end
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL sensor_model c=%0d got=%b want=%b", c, dut_vec, exp_vec());
      end
      tick(1, 0, 0);
    end
  endtask

  task automatic test_ped_early();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      total++;
      if ({ped_walk, phase} !== {(c >= 7 && c <= 9), 3'(dir_phase(c, 4))}) begin
        bad++; $display("FAIL ped_early c=%0d got=%b/%0d want=%b/%0d", c, ped_walk, phase,
                        (c >= 7 && c <= 9), dir_phase(c, 4));
      end
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL ped_early_model c=%0d got=%b want=%b", c, dut_vec, exp_vec());
      end
      tick(0, c == 1, 0);
    end
  endtask

  task automatic test_ped_late();
    do_reset();
    for (int c = 0; c < 21; c++) begin
      total++;
      if ({ped_walk, phase} !== {(c >= 14 && c <= 16), 3'(dir_phase(c, 11))}) begin
        bad++; $display("FAIL ped_late c=%0d got=%b/%0d want=%b/%0d", c, ped_walk, phase,
                        (c >= 14 && c <= 16), dir_phase(c, 11));
      end
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL ped_late_model c=%0d got=%b want=%b", c, dut_vec, exp_vec());
      end
      tick(0, c == 10, 0);
    end
  endtask

  task automatic test_ped_during_side();
    int ph;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      ph = (c < 13) ? dir_phase(c, 4) : dir_phase(c - 13, 4);
      total++;
      if ({ped_walk, phase} !== {(c >= 20 && c <= 22), 3'(ph)}) begin
        bad++; $display("FAIL ped_in_side c=%0d got=%b/%0d want=%b/%0d", c, ped_walk, phase,
                        (c >= 20 && c <= 22), ph);
      end
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL ped_in_side_model c=%0d got=%b want=%b", c, dut_vec, exp_vec());
      end
      tick(c <= 8, c == 8, 0);
    end
  endtask

  task automatic test_reset_mid();
    int ph;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      ph = (c <= 8) ? dir_phase(c, 4) : dir_phase(c - 9, 4);
      total++;
      if ({ped_walk, phase} !== {1'b0, 3'(ph)}) begin
        bad++; $display("FAIL reset_mid c=%0d got=%b/%0d want=0/%0d", c, ped_walk, phase, ph);
      end
      if (c == 9) begin
        total++;
        if (dut_vec !== RESET_VEC) begin
          bad++; $display("FAIL reset_mid_lamps got=%b want=%b", dut_vec, RESET_VEC);
        end
      end
      tick(1, 0, c == 8);
    end
  endtask

  task automatic test_random();
    bit s, p, r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%b want=%b", c, dut_vec, exp_vec());
      end
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 14) == 0);
      r = ($urandom_range(0, 249) == 0);
      tick(s, p, r);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sensor();
    test_ped_early();
    test_ped_late();
    test_ped_during_side();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
